// File: rtl/packer_pkg.sv
// Shared types and helpers for the pop packer.
//   state_e    : COLLECT (building a word) / HOLD (word presented downstream)
//   lane_cnt_w : width of the lane counter for a given beat count
package packer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // One extra bit over $clog2 so BEATS = 1 still gets a 1-bit counter.
  function automatic int unsigned lane_cnt_w(input int unsigned beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/pop_packer.sv
// pop_packer: pops DATA_WIDTH beats from an upstream FIFO and packs BEATS of
// them into one wide word, first beat in the lowest lane.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high
//   pop_valid_i  upstream FIFO holds a beat
//   pop_data_i   upstream beat
//   pop_grant_o  beat is accepted this cycle (when pop_valid_i is high)
//   out_valid_o  packed word available
//   out_data_o   packed word, beat k in lane k
//   out_keep_o   one bit per lane, set when that lane holds data
//   out_ready_i  downstream takes the word
//
// Build option: define PACKER_TIMEOUT_EN to flush a partial word after
// TIMEOUT_CYCLES idle COLLECT cycles. Without it only complete words leave.
//
// state   | meaning
// --------+---------------------------------------------------------
// COLLECT | filling lanes, out_valid_o low
// HOLD    | word presented, data/keep frozen until out_ready_i
module pop_packer
  import packer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BEATS          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pop_valid_i,
  input  logic [DATA_WIDTH-1:0]       pop_data_i,
  output logic                        pop_grant_o,
  output logic                        out_valid_o,
  output logic [DATA_WIDTH*BEATS-1:0] out_data_o,
  output logic [BEATS-1:0]            out_keep_o,
  input  logic                        out_ready_i
);

  localparam int            CW        = lane_cnt_w(BEATS);
  localparam int            OW        = DATA_WIDTH * BEATS;
  localparam logic [CW-1:0] LANE_LAST = CW'(BEATS - 1);

  if (BEATS < 1 || BEATS > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_bad_param
    $error("pop_packer: BEATS or TIMEOUT_CYCLES out of range");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   lane_q, lane_d;
  logic [CW-1:0]   lane_wr;
  logic [OW-1:0]   data_q, data_d;
  logic [BEATS-1:0] keep_q, keep_d;
  logic            accept;
  logic            take;

`ifdef PACKER_TIMEOUT_EN
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] idle_q, idle_d;
`endif

  assign out_valid_o = (state_q == HOLD);
  assign pop_grant_o = !out_valid_o | out_ready_i;
  assign accept      = pop_valid_i & pop_grant_o;
  assign take        = out_valid_o & out_ready_i;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    data_d  = data_q;
    keep_d  = keep_q;
    lane_wr = lane_q;
`ifdef PACKER_TIMEOUT_EN
    idle_d  = '0;
`endif

    // Taking the word clears the lanes first, so a beat accepted in the
    // same cycle lands in lane 0 of a fresh word.
    if (take) begin
      state_d = COLLECT;
      lane_d  = '0;
      data_d  = '0;
      keep_d  = '0;
      lane_wr = '0;
    end

    if (accept) begin
      for (int k = 0; k < BEATS; k++) begin
        if (lane_wr == CW'(k)) begin
          data_d[k*DATA_WIDTH +: DATA_WIDTH] = pop_data_i;
          keep_d[k]                          = 1'b1;
        end
      end
      if (lane_wr == LANE_LAST) begin
        lane_d  = '0;
        state_d = HOLD;
      end else begin
        lane_d = lane_wr + 1'b1;
      end
    end
`ifdef PACKER_TIMEOUT_EN
    // Idle count only runs on a partial word; an accepted beat wins over
    // expiry because this branch is skipped whenever accept is high.
    else if (state_q == COLLECT && lane_q != '0) begin
      if (idle_q == IDLE_LAST) begin
        state_d = HOLD;
        lane_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      lane_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
`ifdef PACKER_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
`ifdef PACKER_TIMEOUT_EN
      idle_q  <= idle_d;
`endif
    end
  end

endmodule

// File: doc/pop_packer.md
POP_PACKER -- requirements
Module: pop_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one input beat.
REQ-002 SHALL have parameter BEATS, default 4: beats per output word, legal range 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: idle cycles before a partial flush, legal range 1..255; used only with PACKER_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port pop_valid_i  input  1  upstream FIFO holds a beat.
REQ-007 SHALL have port pop_data_i  input  DATA_WIDTH  upstream beat.
REQ-008 SHALL have port pop_grant_o  output  1  packer accepts the beat this cycle.
REQ-009 SHALL have port out_valid_o  output  1  packed word available.
REQ-010 SHALL have port out_data_o  output  DATA_WIDTH*BEATS  packed word.
REQ-011 SHALL have port out_keep_o  output  BEATS  one bit per lane, set when that lane holds data.
REQ-012 SHALL have port out_ready_i  input  1  downstream takes the word.

Function
REQ-013 SHALL accept a beat only in a cycle where pop_valid_i & pop_grant_o are both high.
REQ-014 SHALL drive pop_grant_o = !out_valid_o | out_ready_i; this is the only combinational input-to-output path.
REQ-015 SHALL write beat k of a word (k = 0..BEATS-1) into out_data_o[k*DATA_WIDTH +: DATA_WIDTH]; the first beat goes to the lowest lane.
REQ-016 SHALL have two states:
- COLLECT: out_valid_o low.
- HOLD: out_valid_o high; out_data_o and out_keep_o stable until the word is taken.
REQ-017 SHALL go from COLLECT to HOLD on the edge that accepts beat BEATS-1; out_valid_o is high the next cycle (latency 1 from the last beat).
REQ-018 SHALL go from HOLD to COLLECT on out_valid_o & out_ready_i, unless a beat is accepted in the same cycle.
REQ-019 SHALL, when a word is taken and a beat is accepted in the same cycle, store that beat as lane 0 of the next word with no lost cycle. When BEATS = 1 the state stays HOLD, giving one word per cycle.
REQ-020 SHALL use a lane counter of width $clog2(BEATS)+1 that wraps from BEATS-1 to 0.
REQ-021 SHALL hold the counter, data and keep unchanged while pop_valid_i is low.
REQ-022 SHALL, in HOLD with out_ready_i low, hold pop_grant_o low and accept no beat (backpressure reaches the FIFO).
REQ-023 SHALL drive out_keep_o all-ones for every complete word.

Reset
REQ-024 SHALL, on reset high at a clock edge, return to COLLECT with out_valid_o=0, out_data_o=0, out_keep_o=0, lane counter 0 and idle counter 0.
REQ-025 SHALL discard any partial or held word on reset, including reset asserted mid-word; no beat is accepted in a reset cycle.
REQ-026 SHALL give reset priority over every other event.

Configuration
REQ-027 SHALL, with macro PACKER_TIMEOUT_EN defined, count consecutive COLLECT cycles with lane counter >0 and no accepted beat.
REQ-028 SHALL, with PACKER_TIMEOUT_EN defined, enter HOLD when that count reaches TIMEOUT_CYCLES:
- out_keep_o has ones only for filled lanes.
- unfilled lanes are zero.
- the counters reset.
REQ-029 SHALL, with PACKER_TIMEOUT_EN defined, let an accepted beat in the expiry cycle take priority: the beat is stored and the idle count restarts.
REQ-030 SHALL, without PACKER_TIMEOUT_EN, contain no idle counter, ignore TIMEOUT_CYCLES, and emit only complete words.

Structure
REQ-031 SHALL take the state enum (COLLECT, HOLD) and the counter-width helper function from shared package packer_pkg.
REQ-032 SHALL be a single module with no sub-modules; the bench pairs it with the existing fifo as its upstream source.

Verification
REQ-033 SHALL cover this case: DW=8, BEATS=4; push 0x11,0x22,0x33,0x44 back-to-back with ready high -> out_data_o=0x44332211, keep=4'hF, valid one cycle after the 0x44 beat.
REQ-034 SHALL cover this case: ready held low after a word -> pop_grant_o=0 and the word stays stable for 10 cycles; ready high -> the word is taken and the next beat lands in lane 0 in the same cycle.
REQ-035 SHALL cover this case: a continuous 64-beat stream with ready always high -> 16 words, no bubbles, pop_grant_o never low.
REQ-036 SHALL cover this case: reset pulsed after 2 beats (0xAA,0xBB), then 4 beats 0x01..0x04 -> only 0x04030201 is emitted.
REQ-037 SHALL cover this case: with PACKER_TIMEOUT_EN, TIMEOUT_CYCLES=5, push 0x5A, 0x6B then idle -> 5 idle cycles later out_data_o=0x00006B5A, keep=4'b0011.
REQ-038 SHALL cover this case: BEATS=1 -> each beat appears the next cycle; random out_ready_i -> no beat lost or duplicated against a scoreboard.
